n64_flashram_ctrl: RTL

// - Flash save-chip emulator front end. Decodes FlashRAM command/status register accesses and page-buffer writes

---
 rtl/n64_flashram_pkg.sv | 41 ++++
 rtl/n64_flashram_ctrl_if.sv | 24 ++
 rtl/n64_flashram_cmd_decode.sv | 27 ++
 rtl/n64_flashram_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/n64_flashram_pkg.sv
// Shared types and constants for the FlashRAM save-chip front end.
package n64_flashram_pkg;

    typedef enum logic [2:0] {
        MODE_STATUS,
        MODE_READ,
        MODE_ERASE_ARMED,
        MODE_WRITE_LOAD,
        MODE_BUSY
    } e_flashram_mode;

    localparam logic [7:0] CMD_READ         = 8'hF0;
    localparam logic [7:0] CMD_STATUS       = 8'hE1;
    localparam logic [7:0] CMD_ERASE_SECTOR = 8'h4B;
    localparam logic [7:0] CMD_ERASE_CHIP   = 8'h3C;
    localparam logic [7:0] CMD_ERASE_START  = 8'h78;
    localparam logic [7:0] CMD_WRITE_LOAD   = 8'hB4;
    localparam logic [7:0] CMD_WRITE_PAGE   = 8'hA5;
    localparam logic [7:0] CMD_EXECUTE      = 8'hD2;

    localparam int unsigned ST_WRITE_BUSY    = 0;
    localparam int unsigned ST_ERASE_BUSY    = 1;
    localparam int unsigned ST_WRITE_DONE    = 2;
    localparam int unsigned ST_ERASE_DONE    = 3;
    localparam int unsigned ST_TIMEOUT_ERROR = 4;

    localparam int unsigned FLASHRAM_PAGE_HALFWORDS = 64;
    localparam logic [9:0]  SECTOR_MASK             = 10'h380;

    typedef struct packed {
        logic read;
        logic status;
        logic erase_sector;
        logic erase_chip;
        logic erase_start;
        logic write_load;
        logic write_page;
        logic execute;
    } t_cmd_action;

endpackage

// File: rtl/n64_flashram_ctrl_if.sv
// System control bus slice between the FlashRAM front end and the SDRAM controller.
interface n64_scb;
    logic        flashram_pending;
    logic [9:0]  flashram_sector;
    logic        flashram_sector_or_all;
    logic        flashram_write_or_erase;
    logic        flashram_read_mode;
    logic        flashram_write;
    logic [5:0]  flashram_address;
    logic [15:0] flashram_wdata;
    logic        flashram_done;

    modport flashram (
        output flashram_pending, flashram_sector, flashram_sector_or_all, flashram_write_or_erase,
               flashram_read_mode, flashram_write, flashram_address, flashram_wdata,
        input  flashram_done
    );

    modport controller (
        input  flashram_pending, flashram_sector, flashram_sector_or_all, flashram_write_or_erase,
               flashram_read_mode, flashram_write, flashram_address, flashram_wdata,
        output flashram_done
    );
endinterface

// File: rtl/n64_flashram_cmd_decode.sv
// Combinational FlashRAM command byte to one-hot action decode; unknown bytes decode to no action.
module n64_flashram_cmd_decode
    import n64_flashram_pkg::*;
(
    input  logic        valid,
    input  logic [7:0]  cmd,
    output t_cmd_action action
);

    always_comb begin
        action = '0;
        if (valid) begin
            case (cmd)
                CMD_READ:         action.read         = 1'b1;
                CMD_STATUS:       action.status       = 1'b1;
                CMD_ERASE_SECTOR: action.erase_sector = 1'b1;
                CMD_ERASE_CHIP:   action.erase_chip   = 1'b1;
                CMD_ERASE_START:  action.erase_start  = 1'b1;
                CMD_WRITE_LOAD:   action.write_load   = 1'b1;
                CMD_WRITE_PAGE:   action.write_page   = 1'b1;
                CMD_EXECUTE:      action.execute      = 1'b1;
                default:          action              = '0;
            endcase
        end
    end

endmodule

// File: rtl/n64_flashram_ctrl.sv
// FlashRAM command/status front end driving the n64_scb.flashram request signals.
// Optional busy watchdog enabled by defining N64_FLASHRAM_TIMEOUT_EN.
module n64_flashram_ctrl
    import n64_flashram_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write,
    input  logic        reg_address,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    input  logic        buffer_write,
    input  logic [$clog2(FLASHRAM_PAGE_HALFWORDS)-1:0] buffer_address,
    input  logic [15:0] buffer_wdata,
    n64_scb.flashram    n64_scb
);

    e_flashram_mode mode_q, mode_d;
    logic        pending_q, pending_d;
    logic [9:0]  sector_q, sector_d;
    logic        sector_or_all_q, sector_or_all_d;
    logic        write_or_erase_q, write_or_erase_d;
    logic        read_mode_q, read_mode_d;
    logic        write_q, write_d;
    logic [5:0]  address_q, address_d;
    logic [15:0] wdata_q, wdata_d;
    logic [4:0]  status_q, status_d;
    logic [31:0] reg_rdata_q, reg_rdata_d;
    logic        erase_arm_q, erase_arm_d;
    logic        write_load_q, write_load_d;
    logic        write_arm_q, write_arm_d;
    logic        timeout_hit;
    t_cmd_action act;
    logic        unused_wdata_bits;

    assign unused_wdata_bits = ^reg_wdata[23:10];

    n64_flashram_cmd_decode u_cmd_decode (
        .valid  (reg_write && reg_address),
        .cmd    (reg_wdata[31:24]),
        .action (act)
    );

`ifdef N64_FLASHRAM_TIMEOUT_EN
    logic [23:0] tmo_cnt_q, tmo_cnt_d;

    assign timeout_hit = (tmo_cnt_q == TIMEOUT_CYCLES - 24'd1);

    always_comb begin
        tmo_cnt_d = '0;
        if (mode_q == MODE_BUSY && mode_d == MODE_BUSY) tmo_cnt_d = tmo_cnt_q + 24'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) tmo_cnt_q <= '0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic unused_timeout_param;
    assign unused_timeout_param = ^TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        mode_d           = mode_q;
        pending_d        = pending_q;
        sector_d         = sector_q;
        sector_or_all_d  = sector_or_all_q;
        write_or_erase_d = write_or_erase_q;
        write_d          = 1'b0;
        address_d        = address_q;
        wdata_d          = wdata_q;
        status_d         = status_q;
        erase_arm_d      = erase_arm_q;
        write_load_d     = write_load_q;
        write_arm_d      = write_arm_q;

        if (reg_write && !reg_address) status_d[ST_TIMEOUT_ERROR:ST_WRITE_DONE] = '0;

        // Completion is resolved before the command so a coincident command sees the post-done mode.
        if (mode_q == MODE_BUSY) begin
            if (n64_scb.flashram_done) begin
                pending_d               = 1'b0;
                status_d[ST_WRITE_BUSY] = 1'b0;
                status_d[ST_ERASE_BUSY] = 1'b0;
                if (status_q[ST_WRITE_BUSY]) status_d[ST_WRITE_DONE] = 1'b1;
                if (status_q[ST_ERASE_BUSY]) status_d[ST_ERASE_DONE] = 1'b1;
                mode_d = MODE_STATUS;
            end else if (timeout_hit) begin
                pending_d                  = 1'b0;
                status_d[ST_WRITE_BUSY]    = 1'b0;
                status_d[ST_ERASE_BUSY]    = 1'b0;
                status_d[ST_TIMEOUT_ERROR] = 1'b1;
                mode_d = MODE_STATUS;
            end
        end

        if (mode_d != MODE_BUSY) begin
            if (act.read)        mode_d = MODE_READ;
            if (act.status)      mode_d = MODE_STATUS;
            if (act.erase_start) mode_d = MODE_STATUS;
            if (act.erase_sector || act.erase_chip) begin
                if (act.erase_sector) sector_d = reg_wdata[9:0] & SECTOR_MASK;
                sector_or_all_d = act.erase_chip;
                erase_arm_d     = 1'b1;
                write_arm_d     = 1'b0;
                mode_d          = MODE_ERASE_ARMED;
            end
            if (act.write_load) begin
                write_load_d = 1'b1;
                erase_arm_d  = 1'b0;
                mode_d       = MODE_WRITE_LOAD;
            end
            if (act.write_page) begin
                sector_d         = reg_wdata[9:0];
                write_or_erase_d = 1'b1;
                if (write_load_q) begin
                    write_arm_d = 1'b1;
                    erase_arm_d = 1'b0;
                end
            end
            if (act.execute && (erase_arm_q || write_arm_q)) begin
                write_or_erase_d = !erase_arm_q;
                if (erase_arm_q) status_d[ST_ERASE_BUSY] = 1'b1;
                else             status_d[ST_WRITE_BUSY] = 1'b1;
                pending_d    = 1'b1;
                erase_arm_d  = 1'b0;
                write_arm_d  = 1'b0;
                write_load_d = 1'b0;
                mode_d       = MODE_BUSY;
            end
        end

        if (buffer_write && mode_q == MODE_WRITE_LOAD) begin
            write_d   = 1'b1;
            address_d = buffer_address;
            wdata_d   = buffer_wdata;
        end

        read_mode_d = (mode_d == MODE_READ);
        reg_rdata_d = {27'd0, status_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q           <= MODE_STATUS;
            pending_q        <= 1'b0;
            sector_q         <= '0;
            sector_or_all_q  <= 1'b0;
            write_or_erase_q <= 1'b0;
            read_mode_q      <= 1'b0;
            write_q          <= 1'b0;
            address_q        <= '0;
            wdata_q          <= '0;
            status_q         <= '0;
            reg_rdata_q      <= '0;
            erase_arm_q      <= 1'b0;
            write_load_q     <= 1'b0;
            write_arm_q      <= 1'b0;
        end else begin
            mode_q           <= mode_d;
            pending_q        <= pending_d;
            sector_q         <= sector_d;
            sector_or_all_q  <= sector_or_all_d;
            write_or_erase_q <= write_or_erase_d;
            read_mode_q      <= read_mode_d;
            write_q          <= write_d;
            address_q        <= address_d;
            wdata_q          <= wdata_d;
            status_q         <= status_d;
            reg_rdata_q      <= reg_rdata_d;
            erase_arm_q      <= erase_arm_d;
            write_load_q     <= write_load_d;
            write_arm_q      <= write_arm_d;
        end
    end

    assign reg_rdata                       = reg_rdata_q;
    assign n64_scb.flashram_pending        = pending_q;
    assign n64_scb.flashram_sector         = sector_q;
    assign n64_scb.flashram_sector_or_all  = sector_or_all_q;
    assign n64_scb.flashram_write_or_erase = write_or_erase_q;
    assign n64_scb.flashram_read_mode      = read_mode_q;
    assign n64_scb.flashram_write          = write_q;
    assign n64_scb.flashram_address        = address_q;
    assign n64_scb.flashram_wdata          = wdata_q;

endmodule
